// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge controller: byte-granular absorb, SHA3/SHAKE padding, external permutation handshake,
// streamed squeeze with multi-block SHAKE output. Optional abort input when KECCAK_ABORT_EN is defined.
module keccak_sponge_ctrl #(
   parameter int DIN_W  = 64,
   parameter int DOUT_W = 32,
   parameter int D_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [2:0]                cmode,
   input  logic [D_W-1:0]            d,
`ifdef KECCAK_ABORT_EN
   input  logic                      abort,
`endif
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIN_W-1:0]          in_data,
   input  logic                      in_last,
   input  logic [$clog2(DIN_W/8):0]  in_bytes,
   output logic                      perm_start,
   output logic [1599:0]             perm_state_o,
   input  logic                      perm_done,
   input  logic [1599:0]             perm_state_i,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DOUT_W-1:0]         out_data,
   output logic                      out_last,
   output logic                      finish_hash,
   output logic                      busy
);
   // state   | meaning
   // IDLE    | waiting for start
   // ABSORB  | accepting message words into the rate
   // PAD     | one cycle: XOR domain byte and final 0x80 bit
   // PERM    | permutation in flight, return to perm_ret on perm_done
   // SQUEEZE | presenting digest words
   // DONE    | one-cycle finish_hash pulse
   typedef enum logic [2:0] {IDLE, ABSORB, PAD, PERM, SQUEEZE, DONE} state_t;

   localparam int BPW   = DIN_W / 8;
   localparam int OBPW  = DOUT_W / 8;
   localparam int BW_W  = $clog2(BPW) + 1;
   localparam int LEN_W = (D_W > 10) ? D_W : 10;

   state_t            st, st_nxt, perm_ret, ret_nxt;
   logic [1599:0]     sreg, pad_vec;
   logic [2:0]        mode, mode_in;
   logic [LEN_W-1:0]  orem, len_in;
   logic [7:0]        iptr, optr, pad_off, last_off, rbytes, rwi, rwo;
   logic [10:0]       iidx, oidx, pidx, ridx;
   logic [DIN_W-1:0]  in_mask;
   logic [DOUT_W-1:0] omask;
   logic [7:0]        dom;
   logic              perm_go, in_acc, out_acc, sq_last;

   assign mode_in  = (cmode > 3'd5) ? 3'd1 : cmode;
   assign in_acc   = in_valid && (st == ABSORB);
   assign out_acc  = out_ready && (st == SQUEEZE);
   assign sq_last  = orem <= LEN_W'(DOUT_W);
   assign last_off = 8'(iptr * BPW) + 8'(in_bytes);
   assign iidx     = 11'(iptr) * 11'(DIN_W);
   assign oidx     = 11'(optr) * 11'(DOUT_W);
   assign pidx     = {pad_off, 3'b000};
   assign ridx     = {rbytes - 8'd1, 3'b000};
   assign dom      = (mode > 3'd3) ? 8'h1f : 8'h06;

   always_comb begin
      rbytes = 8'd136;
      rwi    = 8'(136 / BPW);
      rwo    = 8'(136 / OBPW);
      case (mode)
         3'd0:    begin rbytes = 8'd144; rwi = 8'(144 / BPW); rwo = 8'(144 / OBPW); end
         3'd2:    begin rbytes = 8'd104; rwi = 8'(104 / BPW); rwo = 8'(104 / OBPW); end
         3'd3:    begin rbytes = 8'd72;  rwi = 8'(72 / BPW);  rwo = 8'(72 / OBPW);  end
         3'd4:    begin rbytes = 8'd168; rwi = 8'(168 / BPW); rwo = 8'(168 / OBPW); end
         default: ;
      endcase
   end

   always_comb begin
      len_in = LEN_W'(d);
      case (mode_in)
         3'd0:    len_in = LEN_W'(224);
         3'd1:    len_in = LEN_W'(256);
         3'd2:    len_in = LEN_W'(384);
         3'd3:    len_in = LEN_W'(512);
         default: ;
      endcase
   end

   always_comb begin
      for (int b = 0; b < BPW; b++)
         in_mask[b*8 +: 8] = (!in_last || (BW_W'(b) < in_bytes)) ? 8'hff : 8'h00;
      omask = '1;
      for (int i = 0; i < DOUT_W; i++)
         if (LEN_W'(i) >= orem) omask[i] = 1'b0;
      pad_vec = '0;
      pad_vec[pidx +: 8] = dom;
      pad_vec[ridx +: 8] = pad_vec[ridx +: 8] ^ 8'h80;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt  = st;
      ret_nxt = perm_ret;
      case (st)
         IDLE:    if (start) st_nxt = ABSORB;
         ABSORB:
            if (in_acc) begin
               if (in_last && last_off == rbytes) begin
                  st_nxt  = PERM;
                  ret_nxt = PAD;
               end else if (in_last) begin
                  st_nxt = PAD;
               end else if (iptr == rwi - 8'd1) begin
                  st_nxt  = PERM;
                  ret_nxt = ABSORB;
               end
            end
         PAD: begin
            st_nxt  = PERM;
            ret_nxt = (orem == '0) ? DONE : SQUEEZE;
         end
         PERM:    if (perm_done) st_nxt = perm_ret;
         SQUEEZE:
            if (out_acc) begin
               if (sq_last) begin
                  st_nxt = DONE;
               end else if (optr == rwo - 8'd1) begin
                  st_nxt  = PERM;
                  ret_nxt = SQUEEZE;
               end
            end
         DONE:    st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
`ifdef KECCAK_ABORT_EN
      if (abort) st_nxt = IDLE;
`endif
   end

   always_comb begin
      in_ready     = (st == ABSORB);
      perm_start   = perm_go;
      perm_state_o = sreg;
      out_valid    = (st == SQUEEZE);
      out_data     = sreg[oidx +: DOUT_W] & omask;
      out_last     = (st == SQUEEZE) && sq_last;
      finish_hash  = (st == DONE);
      busy         = (st != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg     <= '0;
         mode     <= '0;
         orem     <= '0;
         iptr     <= '0;
         optr     <= '0;
         pad_off  <= '0;
         perm_ret <= IDLE;
         perm_go  <= 1'b0;
      end else begin
         perm_go  <= (st_nxt == PERM) && (st != PERM);
         perm_ret <= ret_nxt;
`ifdef KECCAK_ABORT_EN
         if (abort) begin
            sreg <= '0;
            iptr <= '0;
            optr <= '0;
         end else begin
`else
         begin
`endif
            case (st)
               IDLE:
                  if (start) begin
                     sreg    <= '0;
                     mode    <= mode_in;
                     orem    <= len_in;
                     iptr    <= '0;
                     optr    <= '0;
                     pad_off <= '0;
                  end
               ABSORB:
                  if (in_acc) begin
                     sreg[iidx +: DIN_W] <= sreg[iidx +: DIN_W] ^ (in_data & in_mask);
                     // a full last block pushes the pad to offset 0 of a fresh block
                     pad_off <= (last_off == rbytes) ? 8'd0 : last_off;
                     iptr    <= (in_last || iptr == rwi - 8'd1) ? 8'd0 : iptr + 8'd1;
                  end
               PAD:     sreg <= sreg ^ pad_vec;
               PERM:    if (perm_done) sreg <= perm_state_i;
               SQUEEZE:
                  if (out_acc) begin
                     orem <= orem - LEN_W'(DOUT_W);
                     optr <= (optr == rwo - 8'd1) ? 8'd0 : optr + 8'd1;
                  end
               default: ;
            endcase
         end
      end
   end
endmodule
